// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: shifter op codes, FSM state
// encoding and small op-classification helpers.
package shift_seq_pkg;

    // Shifter op codes, shared by the shifter and the sequencer decoder.
    localparam logic [2:0] OP_ASR  = 3'b001;  // arithmetic right
    localparam logic [2:0] OP_LSR  = 3'b010;  // logical right, fill enters at MSB
    localparam logic [2:0] OP_LSL  = 3'b011;  // logical left, fill enters at LSB
    localparam logic [2:0] OP_ROR  = 3'b100;  // rotate right
    localparam logic [2:0] OP_ROL  = 3'b101;  // rotate left
    localparam logic [2:0] OP_SWAP = 3'b110;  // swap the two low nibbles

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // True for codes that actually transform the operand.
    function automatic logic op_is_active(input logic [2:0] op);
        return (op >= OP_ASR) && (op <= OP_SWAP);
    endfunction

    // True for codes that eject the MSB each step.
    function automatic logic op_is_left(input logic [2:0] op);
        return (op == OP_LSL) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_seq_shifter.sv
// Single-step combinational shifter. Holds no state; the sequencer feeds
// its own result register back through it once per RUN cycle.
module shift_seq_shifter
    import shift_seq_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic [BW-1:0] din,
    input  logic [2:0]    sel,
    input  logic          inr,
    input  logic          inl,
    output logic [BW-1:0] dout
);

    // One-position shift/rotate or nibble swap; unknown codes pass through.
    always_comb begin
        dout = din;
        case (sel)
            OP_ASR:  dout = {din[BW-1], din[BW-1:1]};
            OP_LSR:  dout = {inr, din[BW-1:1]};
            OP_LSL:  dout = {din[BW-2:0], inl};
            OP_ROR:  dout = {din[0], din[BW-1:1]};
            OP_ROL:  dout = {din[BW-2:0], din[BW-1]};
            OP_SWAP: dout = {din[BW-1:8], din[3:0], din[7:4]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-bit shift sequencer: iterates a one-step shifter amt times.
// start is accepted only in IDLE or FIN (FIN acceptance gives back-to-back
// operation with no idle cycle); start during RUN is ignored. busy and done
// are plain decodes of the registered state.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int BW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amt,
    input  logic [BW-1:0] din,
    input  logic          fill,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] dout,
    output logic          cout
);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    op_q;
    logic          fill_q;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_load;
    logic [BW-1:0] shifted;
    logic          eject;
    logic          accept;
    logic          direct_fin;

    shift_seq_shifter #(.BW(BW)) u_shifter (
        .din  (dout),
        .sel  (op_q),
        .inr  (fill_q),
        .inl  (fill_q),
        .dout (shifted)
    );

    // Accept decode: a swap is a single step whatever amt says, while a zero
    // count or a pass-through code completes immediately.
    always_comb begin
        accept     = start && ((state == ST_IDLE) || (state == ST_FIN));
        cnt_load   = (op == OP_SWAP) ? AW'(1) : amt;
        direct_fin = (amt == '0) || !op_is_active(op);
    end

    // Bit leaving the register on this step.
    always_comb begin
        eject = dout[0];
        if (op_is_left(op_q)) begin
            eject = dout[BW-1];
        end else if (op_q == OP_SWAP) begin
            eject = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = direct_fin ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                if (cnt == AW'(1)) state_nxt = ST_FIN;
            end
            ST_FIN: begin
                if (accept) state_nxt = direct_fin ? ST_FIN : ST_RUN;
                else        state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Datapath: load on accept, step once per RUN cycle, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= '0;
            cout   <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            fill_q <= 1'b0;
        end else if (accept) begin
            dout   <= din;
            cout   <= 1'b0;
            cnt    <= cnt_load;
            op_q   <= op;
            fill_q <= fill;
        end else if (state == ST_RUN) begin
            dout <= shifted;
            cout <= eject;
            cnt  <= cnt - AW'(1);
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq (BW=16): directed vectors, random operations checked
// against a reference model, start-in-RUN, back-to-back, hold and reset.
module tb_shift_seq;

    localparam int BW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [BW-1:0] din;
    logic          fill;
    logic          busy;
    logic          done;
    logic [BW-1:0] dout;
    logic          cout;

    logic [BW:0] exp_q[$];   // {cout, dout}
    int checks;
    int failures;

    shift_seq #(.BW(BW), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .amt   (amt),
        .din   (din),
        .fill  (fill),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .cout  (cout)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of a complete operation: returns {cout, dout}.
    function automatic logic [BW:0] model(input logic [2:0] o, input logic [AW-1:0] a,
                                          input logic [BW-1:0] d, input logic f);
        logic [BW-1:0] v;
        logic          c;
        int            n;
        v = d;
        c = 1'b0;
        if (a == 0 || o == 3'd0 || o == 3'd7) return {1'b0, d};
        n = (o == 3'd6) ? 1 : int'(a);
        for (int i = 0; i < n; i++) begin
            case (o)
                3'd1: begin c = v[0];  v = {v[15], v[15:1]}; end
                3'd2: begin c = v[0];  v = {f, v[15:1]}; end
                3'd3: begin c = v[15]; v = {v[14:0], f}; end
                3'd4: begin c = v[0];  v = {v[0], v[15:1]}; end
                3'd5: begin c = v[15]; v = {v[14:0], v[15]}; end
                default: begin c = 1'b0; v = {v[15:8], v[3:0], v[7:4]}; end
            endcase
        end
        return {c, v};
    endfunction

    // Cycles from the accepting edge until done is seen.
    function automatic int exp_cycles(input logic [2:0] o, input logic [AW-1:0] a);
        if (a == 0 || o == 3'd0 || o == 3'd7) return 1;
        if (o == 3'd6) return 2;
        return int'(a) + 1;
    endfunction

    // Driver: present a request at a negedge and queue its expected result.
    task automatic issue(input logic [2:0] o, input logic [AW-1:0] a,
                         input logic [BW-1:0] d, input logic f, input logic [BW:0] e);
        op    = o;
        amt   = a;
        din   = d;
        fill  = f;
        start = 1'b1;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for done, check latency and the scoreboarded result.
    task automatic collect(input int exp_cyc, input string name);
        int          cyc;
        bit          seen;
        logic [BW:0] e;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done) seen = 1;
        end
        checks++;
        if (!seen || cyc != exp_cyc) begin
            failures++;
            $display("FAIL %s latency: done at cycle %0d (seen=%0d), required %0d", name, cyc, seen, exp_cyc);
        end
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({cout, dout} !== e) begin
                failures++;
                $display("FAIL %s result: cout=%0b dout=%h, required cout=%0b dout=%h",
                         name, cout, dout, e[BW], e[BW-1:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; amt = '0; din = '0; fill = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, dout} !== {3'b000, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state: busy=%0b done=%0b cout=%0b dout=%h, required all 0", busy, done, cout, dout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        issue(3'b001, 4'd2, 16'h8004, 1'b0, {1'b0, 16'hE001}); collect(3, "asr_8004_2");
        @(negedge clk);
        issue(3'b010, 4'd5, 16'h00F0, 1'b0, {1'b1, 16'h0007}); collect(6, "lsr_00f0_5");
        @(negedge clk);
        issue(3'b010, 4'd4, 16'h00F0, 1'b0, {1'b0, 16'h000F}); collect(5, "lsr_00f0_4");
        @(negedge clk);
        issue(3'b101, 4'd1, 16'h8001, 1'b0, {1'b1, 16'h0003}); collect(2, "rol_8001_1");
        @(negedge clk);
        issue(3'b011, 4'd3, 16'h0001, 1'b1, {1'b0, 16'h000F}); collect(4, "lsl_fill1");
        @(negedge clk);
        issue(3'b110, 4'd7, 16'h12AB, 1'b0, {1'b0, 16'h12BA}); collect(2, "swap_amt7");
        @(negedge clk);
        issue(3'b110, 4'd0, 16'h12AB, 1'b0, {1'b0, 16'h12AB}); collect(1, "swap_amt0");
        @(negedge clk);
        issue(3'b111, 4'd9, 16'hBEEF, 1'b1, {1'b0, 16'hBEEF}); collect(1, "passthru_op7");
        @(negedge clk);
        issue(3'b100, 4'd15, 16'h0001, 1'b0, {1'b0, 16'h0002}); collect(16, "ror_max");
    endtask

    task automatic test_random();
        logic [2:0]    o;
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        logic          f;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            a = AW'($urandom_range(0, 15));
            d = BW'($urandom);
            f = 1'($urandom_range(0, 1));
            @(negedge clk);
            issue(o, a, d, f, model(o, a, d, f));
            collect(exp_cycles(o, a), "random");
        end
    endtask

    task automatic test_start_in_run();
        int cyc;
        bit seen;
        @(negedge clk);
        issue(3'b011, 4'd6, 16'h0101, 1'b0, model(3'b011, 4'd6, 16'h0101, 1'b0));
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 2) begin
                op = 3'b001; amt = 4'd1; din = 16'hFFFF; start = 1'b1;
            end
            if (cyc == 3) start = 1'b0;
            if (done) seen = 1;
        end
        checks++;
        if (!seen || cyc != 7) begin
            failures++;
            $display("FAIL start_in_run latency: done at cycle %0d (seen=%0d), required 7", cyc, seen);
        end
        begin
            logic [BW:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({cout, dout} !== e) begin
                failures++;
                $display("FAIL start_in_run result: cout=%0b dout=%h, required cout=%0b dout=%h",
                         cout, dout, e[BW], e[BW-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(3'b100, 4'd2, 16'h0003, 1'b0, {1'b1, 16'hC000}); collect(3, "b2b_first");
        // done is high now: raise start before FIN's closing edge.
        issue(3'b010, 4'd3, 16'hF000, 1'b1, {1'b0, 16'hFE00}); collect(4, "b2b_second");
        issue(3'b000, 4'd5, 16'h5A5A, 1'b0, {1'b0, 16'h5A5A}); collect(1, "b2b_third");
    endtask

    task automatic test_hold();
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, done, cout, dout} !== {3'b000, 16'h5A5A}) begin
            failures++;
            $display("FAIL hold: busy=%0b done=%0b cout=%0b dout=%h, required 0 0 0 5a5a", busy, done, cout, dout);
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        @(negedge clk);
        issue(3'b011, 4'd8, 16'h00FF, 1'b1, 17'h0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, dout} !== {3'b000, 16'h0000}) begin
            failures++;
            $display("FAIL reset_mid_run clear: busy=%0b done=%0b cout=%0b dout=%h, required all 0", busy, done, cout, dout);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_mid_run aborted: done/busy=1 after reset, required 0");
        end
        issue(3'b001, 4'd3, 16'h8010, 1'b0, {1'b0, 16'hF002}); collect(4, "after_reset");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_random();
        test_start_in_run();
        test_back_to_back();
        test_hold();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
